// File: rtl/counter_monitor.sv
// counter_monitor: watches a free-running up/down counter value and reports
// wrap events (max->0 and 0->max) plus a hysteresis alarm on the count level.
//
// Build option: define COUNTER_MONITOR_WRAPS_EN to enable the saturating
// wrap_count statistic and its clear input. Otherwise wrap_count is tied to 0
// and clear is ignored.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   counter_in sampled count value (WIDTH bits)
//   thr_hi     alarm assert threshold (counter_in >= thr_hi)
//   thr_lo     alarm release threshold (counter_in <= thr_lo)
//   clear      synchronous clear of wrap_count
//   wrap_up    one-cycle pulse, upward wrap max->0 seen on the previous sample
//   wrap_down  one-cycle pulse, downward wrap 0->max seen on the previous sample
//   wrap_count saturating count of wrap events (WRAPS_W bits)
//   alarm      hysteresis alarm state
//   prev_out   previous sample of counter_in
module counter_monitor #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned WRAPS_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   counter_in,
    input  logic [WIDTH-1:0]   thr_hi,
    input  logic [WIDTH-1:0]   thr_lo,
    input  logic               clear,
    output logic               wrap_up,
    output logic               wrap_down,
    output logic [WRAPS_W-1:0] wrap_count,
    output logic               alarm,
    output logic [WIDTH-1:0]   prev_out
);

    localparam logic [WIDTH-1:0] VAL_MAX = '1;

    typedef enum logic {
        NORMAL = 1'b0,
        ALARM  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prev_valid;
    logic   wrap_up_c;
    logic   wrap_down_c;

    // State register, sample history and registered wrap pulses.
    // Reset clears prev_valid so a max->0 caused by a shared reset never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            prev_out   <= '0;
            prev_valid <= 1'b0;
            wrap_up    <= 1'b0;
            wrap_down  <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_out   <= counter_in;
            prev_valid <= 1'b1;
            wrap_up    <= wrap_up_c;
            wrap_down  <= wrap_down_c;
        end
    end

    // Next-state and wrap detection; only the current state's condition is
    // evaluated, so overlapping thresholds toggle the alarm every cycle.
    always_comb begin
        state_nxt   = state;
        wrap_up_c   = prev_valid && (prev_out == VAL_MAX) && (counter_in == '0);
        wrap_down_c = prev_valid && (prev_out == '0) && (counter_in == VAL_MAX);
        case (state)
            NORMAL:  if (counter_in >= thr_hi) state_nxt = ALARM;
            ALARM:   if (counter_in <= thr_lo) state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    assign alarm = (state == ALARM);

`ifdef COUNTER_MONITOR_WRAPS_EN
    localparam logic [WRAPS_W-1:0] CNT_MAX = '1;

    logic wrap_any_c;
    assign wrap_any_c = wrap_up_c | wrap_down_c;

    // Saturating wrap statistic; a wrap coinciding with clear counts as the first.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_count <= '0;
        end else if (clear) begin
            wrap_count <= wrap_any_c ? WRAPS_W'(1) : '0;
        end else if (wrap_any_c && (wrap_count != CNT_MAX)) begin
            wrap_count <= wrap_count + WRAPS_W'(1);
        end
    end
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign wrap_count   = '0;
`endif

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the monitored count value.
REQ-002 Parameter WRAPS_W, default 4: bit width of the wrap event counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 counter_in  input  WIDTH  count value from the upstream up/down counter, sampled every clk.
REQ-006 thr_hi  input  WIDTH  alarm assert threshold, unsigned.
REQ-007 thr_lo  input  WIDTH  alarm release threshold, unsigned.
REQ-008 clear  input  1  synchronous clear of wrap statistics.
REQ-009 wrap_up  output  1  one-cycle pulse: upward wrap detected (max to 0).
REQ-010 wrap_down  output  1  one-cycle pulse: downward wrap detected (0 to max).
REQ-011 wrap_count  output  WRAPS_W  saturating count of wrap events of either direction.
REQ-012 alarm  output  1  hysteresis alarm state.
REQ-013 prev_out  output  WIDTH  registered previous sample of counter_in.

Function
REQ-014 The block SHALL register counter_in into prev_out every cycle, and SHALL set a prev_valid flag on the first sample after reset.
REQ-015 wrap_up SHALL be 1 in cycle n+1 iff prev_valid, prev_out = 2^WIDTH-1 and counter_in = 0 in cycle n; otherwise 0.
REQ-016 wrap_down SHALL be 1 in cycle n+1 iff prev_valid, prev_out = 0 and counter_in = 2^WIDTH-1 in cycle n; otherwise 0.
REQ-017 Any other change in value, including a hold, a step of +/-1, or an arbitrary jump, SHALL produce no wrap pulse.
REQ-018 wrap_up and wrap_down SHALL never be 1 in the same cycle.
REQ-019 wrap_count SHALL increment by 1 for each wrap pulse and SHALL saturate at 2^WRAPS_W-1 without rolling over.
REQ-020 With clear=1 and no wrap in the same cycle, wrap_count SHALL become 0 on the next edge.
REQ-021 With clear=1 and a wrap in the same cycle, wrap_count SHALL become 1 on the next edge.
REQ-022 The alarm FSM SHALL have the states NORMAL (alarm=0) and ALARM (alarm=1), registered, with alarm valid one cycle after the sample.
REQ-023 NORMAL SHALL move to ALARM when counter_in >= thr_hi; otherwise it SHALL stay in NORMAL.
REQ-024 ALARM SHALL move to NORMAL when counter_in <= thr_lo; otherwise it SHALL stay in ALARM.
REQ-025 Each cycle the FSM SHALL evaluate only the condition for the current state. If thr_lo >= thr_hi, alarm may toggle every cycle; this is legal and SHALL NOT be masked.
REQ-026 All comparisons SHALL be unsigned, WIDTH bits, with no extension of the operands.
REQ-027 clear SHALL NOT affect the alarm FSM or prev_out.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set prev_out=0, prev_valid=0, wrap_up=0, wrap_down=0, wrap_count=0, alarm=0 and the FSM to NORMAL.
REQ-029 rst SHALL take priority over clear and over every detection.
REQ-030 The first sample after rst is released SHALL produce no wrap pulse, whatever its value.
REQ-031 rst asserted mid-operation SHALL abort any pending wrap pulse, so that a transition from max to 0 caused by a shared counter reset is never counted.

Configuration
REQ-032 Macro COUNTER_MONITOR_WRAPS_EN SHALL control the wrap statistics.
REQ-033 With COUNTER_MONITOR_WRAPS_EN defined, the block SHALL implement REQ-019..REQ-021.
REQ-034 Without COUNTER_MONITOR_WRAPS_EN, the wrap_count port SHALL remain present but be tied to 0, clear SHALL be ignored, and the wrap pulses and alarm SHALL be unaffected.

Verification
REQ-035 Scenario: rst, then counter_in steps 253,254,255,0,1 -> exactly one wrap_up pulse, in the cycle after 0 is sampled; wrap_count=1.
REQ-036 Scenario: counter_in 2,1,0,255,254 -> exactly one wrap_down pulse; wrap_up stays 0; wrap_count=1.
REQ-037 Scenario: thr_hi=200, thr_lo=100, counter_in ramps 0..255..0 -> alarm rises the cycle after 200 is sampled, stays 1 through 101, and falls the cycle after 100 is sampled.
REQ-038 Scenario: 20 upward wraps with WRAPS_W=4 -> wrap_count=15 and holds; then clear plus a wrap in the same cycle -> wrap_count=1.
REQ-039 Scenario: counter_in=255, then rst for one cycle with counter_in=0, then counter_in=0 -> no wrap pulse and wrap_count=0.
REQ-040 Scenario: same stimulus as REQ-035 built without COUNTER_MONITOR_WRAPS_EN -> wrap_up pulses as before, and wrap_count=0 throughout.
